// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg -- shared constants and types for the parameterised register file.
//
// Contents:
//   RF_DATA_W / RF_ADDR_W : default register width and address width
//   RF_DEPTH              : default number of registers (2**RF_ADDR_W)
//   reg_idx_t             : register index at the default address width
//   reg_word_t            : register word at the default data width
//   rf_depth()            : helper returning 2**addr_w
//
// Optional feature macro used by the files importing this package:
//   REG_FILE_BYPASS_EN (write-to-read forwarding in reg_file_param)
// ---------------------------------------------------------------------------
package rf_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 4;
  localparam int RF_DEPTH  = 1 << RF_ADDR_W;

  typedef logic [RF_ADDR_W-1:0] reg_idx_t;
  typedef logic [RF_DATA_W-1:0] reg_word_t;

  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/rf_storage.sv
// ---------------------------------------------------------------------------
// rf_storage -- register array with one write port and three combinational
// read ports (two addressed, one hard-wired to register LINK_IDX).
//
// Ports:
//   clk     in   clock, all writes on the rising edge
//   rst     in   synchronous active-high reset, clears every register to 0
//   we      in   write enable
//   waddr   in   [ADDR_W-1:0] write address
//   wdata   in   [DATA_W-1:0] write data
//   raddr1  in   [ADDR_W-1:0] read address, port 1
//   raddr2  in   [ADDR_W-1:0] read address, port 2
//   rdata1  out  [DATA_W-1:0] stored contents of register raddr1
//   rdata2  out  [DATA_W-1:0] stored contents of register raddr2
//   rdata3  out  [DATA_W-1:0] stored contents of register LINK_IDX
//
// Reads show stored contents only; any write forwarding (REG_FILE_BYPASS_EN)
// is applied by the parent.
// ---------------------------------------------------------------------------
module rf_storage
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int LINK_IDX = (1 << ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] rdata3
);

  localparam int DEPTH = rf_depth(ADDR_W);

  // Every register must clear on reset, so the array is built from flops
  // rather than a RAM macro; reads are zero-latency muxes.
  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  word_we;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_we
      assign word_we[gi] = we && (waddr == ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (word_we[i]) begin
          mem_reg[i] <= wdata;
        end
      end
    end
  end

  assign rdata1 = mem_reg[raddr1];
  assign rdata2 = mem_reg[raddr2];
  assign rdata3 = mem_reg[LINK_IDX];

endmodule

// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param -- parameterised register file with a write-pending
// scoreboard (one pending bit per register plus a live population count).
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset (wins over all writes/sets)
//   r1, r2     in   [ADDR_W-1:0] read addresses for ports 1 and 2
//   wr         in   [ADDR_W-1:0] write address
//   wd         in   [DATA_W-1:0] write data
//   regwrt     in   write enable; also clears pend[wr]
//   pend_set   in   marks register pend_addr as awaiting a write
//   pend_addr  in   [ADDR_W-1:0] register to mark pending
//   r1out      out  [DATA_W-1:0] contents of register r1
//   r2out      out  [DATA_W-1:0] contents of register r2
//   r3out      out  [DATA_W-1:0] contents of register LINK_IDX
//   r1_busy    out  pending bit of register r1
//   r2_busy    out  pending bit of register r2
//   pend_cnt   out  [ADDR_W:0] number of pending registers
//
// Build option:
//   REG_FILE_BYPASS_EN  when defined, a write in progress is forwarded to any
//                       read port addressing wr in the same cycle, and that
//                       port's busy flag reads as already cleared (unless
//                       pend_set re-marks the same register this cycle).
// ---------------------------------------------------------------------------
module reg_file_param
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int LINK_IDX = (1 << ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] r1,
  input  logic [ADDR_W-1:0] r2,
  input  logic [ADDR_W-1:0] wr,
  input  logic [DATA_W-1:0] wd,
  input  logic              regwrt,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  output logic [DATA_W-1:0] r1out,
  output logic [DATA_W-1:0] r2out,
  output logic [DATA_W-1:0] r3out,
  output logic              r1_busy,
  output logic              r2_busy,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = rf_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_IDX);

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] r1_data;
  logic [DATA_W-1:0] r2_data;
  logic [DATA_W-1:0] r3_data;

  rf_storage #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .LINK_IDX (LINK_IDX)
  ) u_storage (
    .clk    (clk),
    .rst    (rst),
    .we     (regwrt),
    .waddr  (wr),
    .wdata  (wd),
    .raddr1 (r1),
    .raddr2 (r2),
    .rdata1 (r1_data),
    .rdata2 (r2_data),
    .rdata3 (r3_data)
  );

  // -------------------------------------------------------------------------
  // Pending scoreboard
  // -------------------------------------------------------------------------
  logic [DEPTH-1:0]  pend_reg;
  logic [DEPTH-1:0]  pend_next;
  logic [DEPTH-1:0]  set_hit;
  logic [DEPTH-1:0]  clr_hit;
  logic [ADDR_W:0]   pend_cnt_reg;
  logic [ADDR_W:0]   pend_cnt_next;
  logic              cnt_inc;
  logic              cnt_dec;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_pend
      assign set_hit[gi]   = pend_set && (pend_addr == ADDR_W'(gi));
      assign clr_hit[gi]   = regwrt && (wr == ADDR_W'(gi));
      // A new producer issued on the same edge as the old one retires
      // leaves the register pending.
      assign pend_next[gi] = set_hit[gi] | (pend_reg[gi] & ~clr_hit[gi]);
    end
  endgenerate

  // The count is kept incrementally instead of re-summing pend_reg. At most
  // one bit can rise (set on a clear bit) and at most one can fall (clear on
  // a set bit not re-marked), so the count moves by -1, 0 or +1 per edge.
  assign cnt_inc = |(set_hit & ~pend_reg);
  assign cnt_dec = |(clr_hit & pend_reg & ~set_hit);

  always_comb begin
    pend_cnt_next = pend_cnt_reg;
    if (cnt_inc && !cnt_dec) begin
      pend_cnt_next = pend_cnt_reg + 1'b1;
    end else if (cnt_dec && !cnt_inc) begin
      pend_cnt_next = pend_cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg     <= '0;
      pend_cnt_reg <= '0;
    end else begin
      pend_reg     <= pend_next;
      pend_cnt_reg <= pend_cnt_next;
    end
  end

  assign pend_cnt = pend_cnt_reg;

  // -------------------------------------------------------------------------
  // Read-side outputs
  // -------------------------------------------------------------------------
`ifdef REG_FILE_BYPASS_EN
  logic r1_fwd;
  logic r2_fwd;
  logic r3_fwd;

  assign r1_fwd = regwrt && (r1 == wr);
  assign r2_fwd = regwrt && (r2 == wr);
  assign r3_fwd = regwrt && (LINK_ADDR == wr);

  assign r1out = r1_fwd ? wd : r1_data;
  assign r2out = r2_fwd ? wd : r2_data;
  assign r3out = r3_fwd ? wd : r3_data;

  // A forwarded read sees the write as already retired, so its pending bit
  // looks clear unless a new producer is issued to the same register now.
  assign r1_busy = r1_fwd ? (pend_set && (pend_addr == r1)) : pend_reg[r1];
  assign r2_busy = r2_fwd ? (pend_set && (pend_addr == r2)) : pend_reg[r2];
`else
  assign r1out   = r1_data;
  assign r2out   = r2_data;
  assign r3out   = r3_data;
  assign r1_busy = pend_reg[r1];
  assign r2_busy = pend_reg[r2];
`endif

endmodule

// File: tb/tb_reg_file_param.sv
// ---------------------------------------------------------------------------
// tb_reg_file_param -- directed, table-driven bench for reg_file_param at the
// default parameters (DATA_W=16, ADDR_W=4, LINK_IDX=15). Expectations for the
// same-cycle forwarding case follow REG_FILE_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_reg_file_param;
  import rf_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  r1, r2, wr, pend_addr;
  logic [15:0] wd;
  logic        regwrt, pend_set;
  logic [15:0] r1out, r2out, r3out;
  logic        r1_busy, r2_busy;
  logic [4:0]  pend_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_file_param #(
    .DATA_W   (16),
    .ADDR_W   (4),
    .LINK_IDX (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .r1        (r1),
    .r2        (r2),
    .wr        (wr),
    .wd        (wd),
    .regwrt    (regwrt),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .r1out     (r1out),
    .r2out     (r2out),
    .r3out     (r3out),
    .r1_busy   (r1_busy),
    .r2_busy   (r2_busy),
    .pend_cnt  (pend_cnt)
  );

  // Inputs applied for one edge, and the outputs expected once the edge has
  // been taken and the write/set strobes dropped (read addresses held).
  typedef struct {
    logic        rst;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic [3:0]  wr;
    logic [15:0] wd;
    logic        regwrt;
    logic        pend_set;
    logic [3:0]  pend_addr;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [15:0] e3;
    logic        eb1;
    logic        eb2;
    logic [4:0]  ecnt;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drop_strobes();
    rst      = 1'b0;
    regwrt   = 1'b0;
    pend_set = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drop_strobes();
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst = v.rst; r1 = v.r1; r2 = v.r2; wr = v.wr; wd = v.wd;
    regwrt = v.regwrt; pend_set = v.pend_set; pend_addr = v.pend_addr;
    tick();
    chk($sformatf("vec%0d_r1out", idx), 32'(r1out), 32'(v.e1));
    chk($sformatf("vec%0d_r2out", idx), 32'(r2out), 32'(v.e2));
    chk($sformatf("vec%0d_r3out", idx), 32'(r3out), 32'(v.e3));
    chk($sformatf("vec%0d_r1_busy", idx), 32'(r1_busy), 32'(v.eb1));
    chk($sformatf("vec%0d_r2_busy", idx), 32'(r2_busy), 32'(v.eb2));
    chk($sformatf("vec%0d_pend_cnt", idx), 32'(pend_cnt), 32'(v.ecnt));
    $display("vec%0d rst=%0d r1=%0d r2=%0d wr=%0d wd=%h we=%0d ps=%0d pa=%0d -> r1out=%h r2out=%h r3out=%h b1=%0d b2=%0d cnt=%0d",
             idx, v.rst, v.r1, v.r2, v.wr, v.wd, v.regwrt, v.pend_set, v.pend_addr,
             r1out, r2out, r3out, r1_busy, r2_busy, pend_cnt);
  endtask

  initial begin
    logic [15:0] exp_fwd_data;
    logic        exp_fwd_busy;
    logic [15:0] exp_link_data;

    rst = 1'b1; r1 = '0; r2 = '0; wr = '0; wd = '0;
    regwrt = 1'b0; pend_set = 1'b0; pend_addr = '0;

    //          rst r1  r2  wr  wd         we ps pa   e1        e2        e3        b1 b2 cnt
    vecs[0]  = '{1'b1, 4'd0,  4'd1, 4'd0,  16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 5'd0};
    vecs[1]  = '{1'b0, 4'd15, 4'd0, 4'd15, 16'h0001, 1'b1, 1'b0, 4'd0, 16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b0, 5'd0};
    vecs[2]  = '{1'b0, 4'd3,  4'd5, 4'd0,  16'h0000, 1'b0, 1'b1, 4'd3, 16'h0000, 16'h0000, 16'h0001, 1'b1, 1'b0, 5'd1};
    vecs[3]  = '{1'b0, 4'd3,  4'd5, 4'd0,  16'h0000, 1'b0, 1'b1, 4'd5, 16'h0000, 16'h0000, 16'h0001, 1'b1, 1'b1, 5'd2};
    vecs[4]  = '{1'b0, 4'd3,  4'd5, 4'd3,  16'h0033, 1'b1, 1'b0, 4'd0, 16'h0033, 16'h0000, 16'h0001, 1'b0, 1'b1, 5'd1};
    vecs[5]  = '{1'b0, 4'd7,  4'd5, 4'd7,  16'h00AA, 1'b1, 1'b1, 4'd7, 16'h00AA, 16'h0000, 16'h0001, 1'b1, 1'b1, 5'd2};
    vecs[6]  = '{1'b0, 4'd7,  4'd3, 4'd0,  16'h0000, 1'b0, 1'b1, 4'd7, 16'h00AA, 16'h0033, 16'h0001, 1'b1, 1'b0, 5'd2};
    vecs[7]  = '{1'b0, 4'd9,  4'd5, 4'd5,  16'h5555, 1'b1, 1'b1, 4'd9, 16'h0000, 16'h5555, 16'h0001, 1'b1, 1'b0, 5'd2};
    vecs[8]  = '{1'b0, 4'd2,  4'd7, 4'd2,  16'h1234, 1'b1, 1'b0, 4'd0, 16'h1234, 16'h00AA, 16'h0001, 1'b0, 1'b1, 5'd2};
    vecs[9]  = '{1'b0, 4'd15, 4'd9, 4'd15, 16'hBEEF, 1'b1, 1'b0, 4'd0, 16'hBEEF, 16'h0000, 16'hBEEF, 1'b0, 1'b1, 5'd2};
    vecs[10] = '{1'b1, 4'd4,  4'd6, 4'd4,  16'hFFFF, 1'b1, 1'b1, 4'd6, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 5'd0};

    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i], i);
      if (i == 0) begin
        // Every address reads back zero after reset.
        for (int a = 0; a < 16; a++) begin
          r1 = 4'(a);
          r2 = 4'(15 - a);
          #1;
          chk($sformatf("rst_sweep%0d_r1out", a), 32'(r1out), 32'h0);
          chk($sformatf("rst_sweep%0d_r2out", a), 32'(r2out), 32'h0);
          chk($sformatf("rst_sweep%0d_busy", a), 32'({r1_busy, r2_busy}), 32'h0);
        end
        $display("rst_sweep all 16 addresses read back, pend_cnt=%0d", pend_cnt);
      end
    end

    // Same-cycle visibility of a write. Register 2 first holds 0x1111 and is
    // left pending (set and write on the same edge).
    @(negedge clk);
    wr = 4'd2; wd = 16'h1111; regwrt = 1'b1; pend_set = 1'b1; pend_addr = 4'd2;
    r1 = 4'd2; r2 = 4'd0;
    tick();
    chk("fwd_setup_r1out", 32'(r1out), 32'h1111);
    chk("fwd_setup_busy", 32'(r1_busy), 32'h1);
    chk("fwd_setup_cnt", 32'(pend_cnt), 32'h1);
    @(negedge clk);
    wr = 4'd2; wd = 16'h1234; regwrt = 1'b1;
    #1;
`ifdef REG_FILE_BYPASS_EN
    exp_fwd_data = 16'h1234; exp_fwd_busy = 1'b0;
`else
    exp_fwd_data = 16'h1111; exp_fwd_busy = 1'b1;
`endif
    chk("fwd_same_cycle_r1out", 32'(r1out), 32'(exp_fwd_data));
    chk("fwd_same_cycle_busy", 32'(r1_busy), 32'(exp_fwd_busy));
    $display("fwd same cycle r1out=%h r1_busy=%0d", r1out, r1_busy);
    tick();
    chk("fwd_after_edge_r1out", 32'(r1out), 32'h1234);
    chk("fwd_after_edge_busy", 32'(r1_busy), 32'h0);
    chk("fwd_after_edge_cnt", 32'(pend_cnt), 32'h0);
    $display("fwd after edge r1out=%h r1_busy=%0d cnt=%0d", r1out, r1_busy, pend_cnt);

    // Link register forwarding (register 15 is 0 since the last reset).
    @(negedge clk);
    wr = 4'd15; wd = 16'h7777; regwrt = 1'b1;
    #1;
`ifdef REG_FILE_BYPASS_EN
    exp_link_data = 16'h7777;
`else
    exp_link_data = 16'h0000;
`endif
    chk("fwd_link_same_cycle", 32'(r3out), 32'(exp_link_data));
    tick();
    chk("fwd_link_after_edge", 32'(r3out), 32'h7777);
    $display("link write r3out=%h", r3out);

    // Fill the scoreboard to DEPTH, re-mark an already pending register,
    // then retire everything.
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      pend_set = 1'b1; pend_addr = 4'(a);
      tick();
    end
    chk("fill_cnt_full", 32'(pend_cnt), 32'd16);
    @(negedge clk);
    pend_set = 1'b1; pend_addr = 4'd0; r1 = 4'd0; r2 = 4'd15;
    tick();
    chk("fill_reset_again_cnt", 32'(pend_cnt), 32'd16);
    chk("fill_busy_both", 32'({r1_busy, r2_busy}), 32'h3);
    $display("scoreboard full cnt=%0d", pend_cnt);
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      regwrt = 1'b1; wr = 4'(a); wd = 16'(a * 16'h0101);
      tick();
      if (a == 7) begin
        chk("drain_half_cnt", 32'(pend_cnt), 32'd8);
      end
    end
    chk("drain_cnt_zero", 32'(pend_cnt), 32'd0);
    r1 = 4'd6; r2 = 4'd15;
    #1;
    chk("drain_r1out", 32'(r1out), 32'h0606);
    chk("drain_r3out", 32'(r3out), 32'h0F0F);
    chk("drain_busy", 32'({r1_busy, r2_busy}), 32'h0);
    $display("scoreboard drained cnt=%0d r1out=%h r3out=%h", pend_cnt, r1out, r3out);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter DATA_W, default 16, register width in bits.
REQ-002 Parameter ADDR_W, default 4, address width; depth DEPTH = 2**ADDR_W.
REQ-003 Parameter LINK_IDX, default DEPTH-1, index of the register driven continuously on r3out.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 r1, r2  input  ADDR_W  read addresses for ports 1 and 2.
REQ-007 wr  input  ADDR_W  write address.
REQ-008 wd  input  DATA_W  write data.
REQ-009 regwrt  input  1  write enable.
REQ-010 pend_set  input  1  marks register pend_addr as awaiting a write (scoreboard issue).
REQ-011 pend_addr  input  ADDR_W  register marked pending.
REQ-012 r1out, r2out  output  DATA_W  read data for ports 1 and 2.
REQ-013 r3out  output  DATA_W  contents of register LINK_IDX.
REQ-014 r1_busy, r2_busy  output  1  pending bit of the register addressed by r1 or r2.
REQ-015 pend_cnt  output  ADDR_W+1  number of registers currently pending.

Function
REQ-016 Reads are combinational: r1out = reg[r1], r2out = reg[r2], r3out = reg[LINK_IDX], zero-latency.
REQ-017 Write: when regwrt=1 at a rising edge, reg[wr] <= wd; visible on outputs after that edge.
REQ-018 A write to register wr with regwrt=1 clears pend[wr] at the same edge.
REQ-019 pend_set=1 sets pend[pend_addr] at the rising edge.
REQ-020 Same edge, pend_set and regwrt with pend_addr == wr: pend ends set (new producer wins); data is still written.
REQ-021 pend_set on an already-pending register: no change; pend_cnt unchanged.
REQ-022 regwrt on a non-pending register: data written, pend unchanged.
REQ-023 pend_cnt tracks the set bits exactly: +1 per new set, -1 per clear, net 0 when one register is set and a different one is cleared on the same edge.
REQ-024 pend_cnt never exceeds DEPTH; it is the population count of pend[] at all times.
REQ-025 r1_busy/r2_busy are combinational from pend[] and the current read addresses.

Reset
REQ-026 rst=1 at a rising edge clears all registers to 0, all pend bits to 0 and pend_cnt to 0.
REQ-027 rst takes priority over regwrt and pend_set at the same edge.
REQ-028 After reset: r1out = r2out = r3out = 0, r1_busy = r2_busy = 0, pend_cnt = 0.

Configuration
REQ-029 Macro REG_FILE_BYPASS_EN defined: if regwrt=1 and r1 (or r2, or LINK_IDX) == wr, the corresponding output shows wd combinationally in the same cycle, and its busy flag reads 0 unless pend_set targets the same address in that cycle.
REQ-030 REG_FILE_BYPASS_EN undefined: no forwarding; outputs show stored contents only, and busy flags reflect stored pend[].

Structure
REQ-031 A shared package rf_pkg holds the default DATA_W/ADDR_W constants and the reg-index type.
REQ-032 The storage array plus read muxes form one natural sub-module, rf_storage.
REQ-033 Scoreboard bits and pend_cnt live in the top module.

Verification
REQ-034 Reset then read every address -> all outputs 0, pend_cnt=0.
REQ-035 Write wr=15, wd=0x0001 -> next cycle r3out=0x0001; r1=15 gives r1out=0x0001.
REQ-036 pend_set addr 3, then pend_set addr 5 -> pend_cnt=2; write addr 3 -> pend_cnt=1, r1=3 gives r1_busy=0.
REQ-037 Same edge: pend_set addr 7 and regwrt wr=7, wd=0x00AA -> reg[7]=0x00AA, pend[7]=1, pend_cnt +1.
REQ-038 With BYPASS_EN: regwrt wr=2, wd=0x1234, r1=2 -> r1out=0x1234 in the same cycle; without the macro -> old value until the edge.
REQ-039 rst asserted with regwrt and pend_set active -> all state 0 after the edge.
